// File: rtl/bus_ticket_issue.sv
// Bus ticket issuer: turns a completed booking into a numbered ticket for one seat.
// It keeps a seat occupancy map and a free-seat count, rejects bookings it
// cannot honour, and frees seats on cancel while idle.
module bus_ticket_issue #(
  parameter int SEATS = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       booked,
  input  logic [5:0] seat_req,
  input  logic       cancel,
  input  logic [5:0] cancel_seat,
  input  logic       ack,
  output logic       ticket_valid,
  output logic [7:0] ticket_id,
  output logic [5:0] seat_no,
  output logic       reject,
  output logic [5:0] seats_left,
  output logic       sold_out,
  output logic       busy
);

  localparam logic [5:0] SEATS_W = 6'(SEATS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    ISSUE  = 2'd2,
    REJECT = 2'd3
  } state_t;

  // Reads map bit idx; any idx at or above SEATS reads as 0.
  function automatic logic map_bit(input logic [SEATS-1:0] m, input logic [5:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < SEATS; i++) begin
      r = r | (m[i] & (6'(i) == idx));
    end
    return r;
  endfunction

  // One-hot mask for seat idx; all zero when idx is at or above SEATS.
  function automatic logic [SEATS-1:0] seat_mask(input logic [5:0] idx);
    logic [SEATS-1:0] r;
    for (int i = 0; i < SEATS; i++) begin
      r[i] = (6'(i) == idx);
    end
    return r;
  endfunction

  state_t           state_r, state_nxt_s;
  logic             booked_q_r;
  logic [5:0]       seat_cap_r, seat_cap_nxt_s;
  logic [SEATS-1:0] map_r, map_nxt_s;
  logic [5:0]       left_r, left_nxt_s;
  logic [7:0]       id_r, id_nxt_s;
  logic [5:0]       seat_no_r, seat_no_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic             reject_r, reject_nxt_s;
  logic             edge_s;
  logic             sold_out_s;
  logic             cancel_ok_s;
  logic             req_bad_s;

  assign edge_s      = booked & ~booked_q_r;
  assign sold_out_s  = (left_r == 6'd0);
  // A cancel only frees a seat that exists and is actually taken.
  assign cancel_ok_s = (cancel_seat < SEATS_W) && map_bit(map_r, cancel_seat) && (left_r != SEATS_W);
  // A booking fails on an out-of-range seat, a taken seat, or a full bus.
  assign req_bad_s   = (seat_cap_r >= SEATS_W) || map_bit(map_r, seat_cap_r) || sold_out_s;

  // Next-state and next-value logic for the booking/issue sequence and cancels.
  always_comb begin
    state_nxt_s    = state_r;
    seat_cap_nxt_s = seat_cap_r;
    map_nxt_s      = map_r;
    left_nxt_s     = left_r;
    id_nxt_s       = id_r;
    seat_no_nxt_s  = seat_no_r;
    valid_nxt_s    = valid_r;
    reject_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (edge_s) begin
          // Booking beats a cancel arriving in the same cycle.
          seat_cap_nxt_s = seat_req;
          state_nxt_s    = CHECK;
        end else if (cancel && cancel_ok_s) begin
          map_nxt_s  = map_r & ~seat_mask(cancel_seat);
          left_nxt_s = left_r + 6'd1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CHECK: begin
        if (req_bad_s) begin
          reject_nxt_s = 1'b1;
          state_nxt_s  = REJECT;
        end else begin
          map_nxt_s     = map_r | seat_mask(seat_cap_r);
          left_nxt_s    = left_r - 6'd1;
          id_nxt_s      = id_r + 8'd1;
          seat_no_nxt_s = seat_cap_r;
          valid_nxt_s   = 1'b1;
          state_nxt_s   = ISSUE;
        end
      end
      ISSUE: begin
        if (ack) begin
          valid_nxt_s = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      REJECT: begin
        state_nxt_s = IDLE;
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, occupancy, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      booked_q_r <= 1'b0;
      seat_cap_r <= 6'd0;
      map_r      <= '0;
      left_r     <= SEATS_W;
      id_r       <= 8'd0;
      seat_no_r  <= 6'd0;
      valid_r    <= 1'b0;
      reject_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      booked_q_r <= booked;
      seat_cap_r <= seat_cap_nxt_s;
      map_r      <= map_nxt_s;
      left_r     <= left_nxt_s;
      id_r       <= id_nxt_s;
      seat_no_r  <= seat_no_nxt_s;
      valid_r    <= valid_nxt_s;
      reject_r   <= reject_nxt_s;
    end
  end

  assign ticket_valid = valid_r;
  assign ticket_id    = id_r;
  assign seat_no      = seat_no_r;
  assign reject       = reject_r;
  assign seats_left   = left_r;
  assign sold_out     = sold_out_s;
  assign busy         = (state_r != IDLE);

endmodule

// File: tb/tb_bus_ticket_issue.sv
// Scoreboard bench for bus_ticket_issue: the driver predicts each booking's
// outcome and queues it; a monitor pops and compares on every ticket or reject.
module tb_bus_ticket_issue;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       booked = 1'b0;
  logic [5:0] seat_req = 6'd0;
  logic       cancel = 1'b0;
  logic [5:0] cancel_seat = 6'd0;
  logic       ack = 1'b0;
  logic       ticket_valid;
  logic [7:0] ticket_id;
  logic [5:0] seat_no;
  logic       reject;
  logic [5:0] seats_left;
  logic       sold_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       is_rej;
    logic [7:0] id;
    logic [5:0] seat;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] exp_map = 64'd0;
  int          exp_left = 40;
  logic [7:0]  exp_id = 8'd0;

  bus_ticket_issue #(.SEATS(40)) dut (
    .clk(clk), .rst(rst), .booked(booked), .seat_req(seat_req),
    .cancel(cancel), .cancel_seat(cancel_seat), .ack(ack),
    .ticket_valid(ticket_valid), .ticket_id(ticket_id), .seat_no(seat_no),
    .reject(reject), .seats_left(seats_left), .sold_out(sold_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: one scoreboard entry per newly presented ticket or reject pulse.
  initial begin
    logic pv;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pv = 1'b0;
      end else begin
        if (ticket_valid && !pv) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ticket: got id %0d seat %0d, expected none", ticket_id, seat_no);
          end else begin
            e = sb.pop_front();
            check("sb_kind_ticket", 32'd0, {31'd0, e.is_rej});
            check("sb_ticket_id", {24'd0, ticket_id}, {24'd0, e.id});
            check("sb_seat_no", {26'd0, seat_no}, {26'd0, e.seat});
          end
        end
        if (reject) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_reject: got reject 1, expected 0");
          end else begin
            e = sb.pop_front();
            check("sb_kind_reject", 32'd1, {31'd0, e.is_rej});
          end
        end
        pv = ticket_valid;
      end
    end
  end

  // Waits for a ticket or reject after a booking edge and checks the latency.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (i == 1) cancel = 1'b0;
      if (ticket_valid || reject) lat = i;
      if (lat != 0) break;
    end
    check("latency", lat, 32'd2);
  endtask

  task automatic ack_ticket();
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1;
    check("valid_drop_after_ack", {31'd0, ticket_valid}, 32'd0);
    @(negedge clk); ack = 1'b0;
  endtask

  task automatic book(input logic [5:0] s, input int hold, input bit cx_same,
                      input logic [5:0] cs, input bit cx_issue, input bit do_ack);
    bit rej;
    int lat;
    rej = (s >= 6'd40) || exp_map[s] || (exp_left == 0);
    if (rej) begin
      sb.push_back(exp_t'{1'b1, 8'd0, 6'd0});
    end else begin
      exp_map[s] = 1'b1;
      exp_left--;
      exp_id = exp_id + 8'd1;
      sb.push_back(exp_t'{1'b0, exp_id, s});
    end
    @(negedge clk);
    seat_req = s;
    booked = 1'b1;
    if (cx_same) begin
      cancel = 1'b1;
      cancel_seat = cs;
    end
    wait_out(lat);
    if (rej) begin
      @(posedge clk); #1;
      check("reject_one_cycle", {31'd0, reject}, 32'd0);
      check("busy_after_reject", {31'd0, busy}, 32'd0);
    end else begin
      if (cx_issue) begin
        @(negedge clk); cancel = 1'b1; cancel_seat = cs;
        @(negedge clk); cancel = 1'b0;
        check("valid_held", {31'd0, ticket_valid}, 32'd1);
      end
      if (do_ack) ack_ticket();
    end
    check("seats_left", {26'd0, seats_left}, exp_left);
    check("sold_out", {31'd0, sold_out}, {31'd0, exp_left == 0});
    if (do_ack || rej) begin
      repeat (hold) @(negedge clk);
      check("idle_after_booking", {31'd0, busy}, 32'd0);
      booked = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic cancel_s(input logic [5:0] s);
    if ((s < 6'd40) && exp_map[s]) begin
      exp_map[s] = 1'b0;
      exp_left++;
    end
    @(negedge clk); cancel = 1'b1; cancel_seat = s;
    @(negedge clk); cancel = 1'b0;
    check("seats_left_cancel", {26'd0, seats_left}, exp_left);
  endtask

  // Directed stimulus sequence.
  initial begin
    int lat;
    int guard;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, ticket_valid}, 32'd0);
    check("rst_reject", {31'd0, reject}, 32'd0);
    check("rst_seats_left", {26'd0, seats_left}, 32'd40);
    check("rst_sold_out", {31'd0, sold_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ticket_id", {24'd0, ticket_id}, 32'd0);
    check("rst_seat_no", {26'd0, seat_no}, 32'd0);
    @(negedge clk); rst = 1'b1;

    book(6'd5, 0, 1'b0, 6'd0, 1'b0, 1'b1);
    book(6'd5, 0, 1'b0, 6'd0, 1'b0, 1'b1);
    book(6'd45, 10, 1'b0, 6'd0, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      if (i != 5) book(6'(i), 0, 1'b0, 6'd0, 1'b0, 1'b1);
    end
    check("full_sold_out", {31'd0, sold_out}, 32'd1);
    book(6'd10, 0, 1'b0, 6'd0, 1'b0, 1'b1);
    cancel_s(6'd50);
    cancel_s(6'd7);
    check("after_cancel_sold_out", {31'd0, sold_out}, 32'd0);
    book(6'd7, 0, 1'b0, 6'd0, 1'b0, 1'b1);

    cancel_s(6'd3);
    book(6'd20, 0, 1'b1, 6'd20, 1'b0, 1'b1);
    book(6'd20, 0, 1'b0, 6'd0, 1'b0, 1'b1);
    book(6'd3, 0, 1'b0, 6'd0, 1'b1, 1'b1);
    check("cancel_in_issue_ignored", {26'd0, seats_left}, 32'd0);

    guard = 0;
    do begin
      cancel_s(6'd3);
      book(6'd3, 0, 1'b0, 6'd0, 1'b0, 1'b1);
      guard++;
    end while ((exp_id != 8'd0) && (guard < 300));
    check("wrap_ticket_id", {24'd0, ticket_id}, 32'd0);

    cancel_s(6'd3);
    book(6'd3, 0, 1'b0, 6'd0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("midissue_rst_valid", {31'd0, ticket_valid}, 32'd0);
    check("midissue_rst_seats_left", {26'd0, seats_left}, 32'd40);
    check("midissue_rst_ticket_id", {24'd0, ticket_id}, 32'd0);
    check("midissue_rst_busy", {31'd0, busy}, 32'd0);
    exp_map = 64'd0;
    exp_left = 40;
    exp_id = 8'd0;

    seat_req = 6'd9;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_map[9] = 1'b1;
    exp_left--;
    exp_id = exp_id + 8'd1;
    sb.push_back(exp_t'{1'b0, exp_id, 6'd9});
    wait_out(lat);
    ack_ticket();
    check("booked_high_at_release", {26'd0, seats_left}, 32'd39);
    booked = 1'b0;
    repeat (3) @(negedge clk);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Run-time bound so a stuck design cannot hang the bench.
  initial begin
    #500000;
    $display("FAIL timeout: got no completion, expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_ticket_issue.md
BUS_TICKET_ISSUE -- requirements
Module: bus_ticket_issue

Interface
REQ-001 SHALL have parameter SEATS, default 40, number of bookable seats (1..63).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port booked  input  1  booking-complete level from the booking FSM; high while booking is in its done state.
REQ-005 SHALL have port seat_req  input  6  requested seat number, sampled on the booked rising edge.
REQ-006 SHALL have port cancel  input  1  single-cycle cancel request.
REQ-007 SHALL have port cancel_seat  input  6  seat to release with cancel.
REQ-008 SHALL have port ack  input  1  ticket consumer accepts the presented ticket.
REQ-009 SHALL have port ticket_valid  output  1  ticket presented, held until ack.
REQ-010 SHALL have port ticket_id  output  8  serial number of the presented or last ticket.
REQ-011 SHALL have port seat_no  output  6  seat bound to the presented or last ticket.
REQ-012 SHALL have port reject  output  1  one-cycle pulse when a booking cannot be honoured.
REQ-013 SHALL have port seats_left  output  6  count of free seats.
REQ-014 SHALL have port sold_out  output  1  high when seats_left == 0.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL keep a SEATS-bit occupancy map, bit n = seat n taken.
REQ-017 SHALL detect booking as booked high with its registered previous value low (rising edge); a held-high level SHALL NOT re-trigger.
REQ-018 SHALL implement FSM states IDLE, CHECK, ISSUE, REJECT.
REQ-019 IDLE: on booking edge SHALL capture seat_req and go to CHECK next cycle; otherwise stay.
REQ-020 CHECK (exactly 1 cycle): seat_req >= SEATS, seat taken, or sold_out -> REJECT; else set map bit, decrement seats_left, increment ticket_id (8-bit, 255 wraps to 0), load seat_no -> ISSUE.
REQ-021 ISSUE: ticket_valid high with ticket_id/seat_no stable; on ack go to IDLE, ticket_valid low next cycle.
REQ-022 REJECT: reject high for exactly one cycle, then IDLE; map, seats_left and ticket_id unchanged.
REQ-023 Latency booking edge -> ticket_valid SHALL be 2 clock cycles; edge -> reject also 2 cycles.
REQ-024 ack when ticket_valid is low SHALL be ignored.
REQ-025 Booking edge while busy SHALL be dropped with no state change; edge detector still updates.
REQ-026 cancel SHALL be honoured only in IDLE with no simultaneous booking edge: if cancel_seat < SEATS and bit set, clear bit and increment seats_left next cycle; otherwise ignored.
REQ-027 Booking edge and cancel in the same IDLE cycle: booking SHALL win, cancel SHALL be dropped.
REQ-028 cancel while busy SHALL be dropped.
REQ-029 seats_left SHALL never underflow below 0 nor exceed SEATS.
REQ-030 sold_out SHALL be combinational from seats_left.

Reset
REQ-031 rst low SHALL immediately force state IDLE, map all clear, seats_left = SEATS, ticket_id = 0, seat_no = 0, ticket_valid = 0, reject = 0, edge-detect register = 0.
REQ-032 Reset asserted mid-ISSUE SHALL drop the pending ticket with no ack required.
REQ-033 After rst release with booked already high, the first sampled high SHALL count as a booking edge.

Verification
REQ-034 Reset, booked 0->1 with seat_req=5, ack 1 cycle after valid -> ticket_valid on 2nd edge, ticket_id=1, seat_no=5, seats_left=39.
REQ-035 Second booking seat_req=5 -> reject pulse 1 cycle, seats_left stays 39, ticket_id stays 1.
REQ-036 Booking seat_req=45 (SEATS=40) -> reject; booked held high 10 cycles -> no further activity.
REQ-037 Fill all 40 seats -> sold_out=1; 41st booking -> reject; cancel seat 7 -> seats_left=1, sold_out=0; rebook seat 7 -> ticket issued.
REQ-038 Booking edge and cancel same cycle -> booking processed, cancelled seat still taken; cancel during ISSUE -> ignored.
REQ-039 Issue 256 tickets with cancel between -> ticket_id wraps 255->0; rst low during ISSUE -> ticket_valid 0 immediately, seats_left=40.
